calc_req_mux: RTL
=================

Name: calc_req_mux

Overview:
- Parametrised multi-port request front-end for the calculator engine.
- Accepts request bundles from NUM_PORTS independent requesters: cmd, data, d1, d2, r1 and tag.
- Buffers each port's requests in a per-port FIFO, round-robin arbitrates them onto one valid/ready engine channel, and routes engine responses back to the originating port.
- Originating port is identified by port-ID bits prepended to the tag.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- FIFO_DEPTH, 4, entries per port FIFO (power of 2, >=2).
- DATA_W, 32, operand/result data width.
- CMD_W, 4, command width; cmd==0 means no request.
- REG_W, 4, register-address width of d1/d2/r1.
- TAG_W, 2, requester tag width.
- PID_W, $clog2(NUM_PORTS), port-ID width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_cmd_in  in  NUM_PORTS*CMD_W  per-port command; nonzero = request present this cycle.
- req_data_in  in  NUM_PORTS*DATA_W  per-port data.
- req_d1, req_d2, req_r1  in  NUM_PORTS*REG_W each  per-port register addresses.
- req_tag_in  in  NUM_PORTS*TAG_W  per-port tag.
- req_accept  out  NUM_PORTS  port FIFO not full.
- drop_err  out  NUM_PORTS  sticky: a request was presented while full.
- eng_valid  out  1  engine request valid.
- eng_ready  in  1  engine accepts request.
- eng_cmd, eng_data, eng_d1, eng_d2, eng_r1  out  CMD_W/DATA_W/REG_W  engine request fields.
- eng_tag  out  PID_W+TAG_W  {port_id, tag}.
- eng_resp  in  2  engine response code; 0 = none.
- eng_resp_data  in  DATA_W  engine result.
- eng_resp_tag  in  PID_W+TAG_W  tag of the response.
- out_resp  out  NUM_PORTS*2  per-port response code.
- out_data  out  NUM_PORTS*DATA_W  per-port result.
- out_tag  out  NUM_PORTS*TAG_W  per-port tag.

Behaviour:
- Clock/reset: one clock (clk); asynchronous active-high reset (rst). Asserting rst clears everything immediately, including in-flight eng_valid; nothing is replayed.
- Reset values: all FIFOs empty; req_accept all 1; drop_err 0; eng_valid 0 and all eng_* fields 0; out_resp/out_data/out_tag 0; round-robin pointer 0.
- Push: at a rising edge, port p pushes {cmd, data, d1, d2, r1, tag} when req_cmd_in[p]!=0 and its FIFO is not full.
  - req_accept[p] = ~full[p], derived from registered count; it is not combinationally dependent on a same-cycle pop.
- Drop: cmd!=0 while full discards the request and sets drop_err[p]. drop_err clears only on rst.
- Output register: a single register slot drives eng_*.
  - Slot is free when eng_valid==0, or when eng_valid&&eng_ready this cycle.
  - When the slot is free and any FIFO is non-empty, the arbiter grants the first non-empty port at or after the pointer (wrapping modulo NUM_PORTS).
  - The granted head is popped and loaded into the slot; eng_valid=1; eng_tag={granted_id, tag}; pointer <= granted_id+1 (mod NUM_PORTS).
  - If the slot is free and no FIFO is non-empty, eng_valid <= 0.
  - eng_* fields are held stable while eng_valid && !eng_ready.
- Latency: push at edge k -> eng_valid at edge k+1 at the earliest. Throughput is one request per cycle with eng_ready held high.
- Simultaneous push and pop on the same FIFO: both occur; count unchanged. When a full FIFO is popped, req_accept rises the following cycle.
- Response routing: when eng_resp!=0 at edge k, port pid=eng_resp_tag[upper PID_W] gets, after edge k:
  - out_resp = eng_resp;
  - out_data = eng_resp_data;
  - out_tag = eng_resp_tag[lower TAG_W].
  - All other ports, and all ports when eng_resp==0, drive out_resp=0 with out_data/out_tag holding their previous values.
- A pid >= NUM_PORTS is discarded.
- Responses are independent of the request path; no ordering is enforced.

Decomposition:
- Package calc_mux_pkg: response-code constants RESP_NONE=2'b00 and RESP_OK=2'b01 (others passed through unchanged), CMD_NOP=0, and a packed struct req_t {cmd, data, d1, d2, r1, tag}.
- One sub-module, calc_req_fifo: parametrised synchronous FIFO of req_t with push, pop, full, empty and count, instantiated NUM_PORTS times.
- Arbiter and response demux stay inline.

Test Plan:
- Reset defaults: assert rst mid-traffic with eng_valid=1 -> eng_valid=0 immediately, req_accept=4'b1111, out_resp=0, drop_err=0.
- Single request with eng_ready=1: port 2 sends cmd=1, data=32'h0000_0005, d1=1, d2=2, r1=3, tag=1 at edge k -> after edge k+1, eng_valid=1, eng_tag=4'b10_01, fields match.
- Round-robin: all 4 ports send one request the same cycle, eng_ready=1 -> eng_tag port IDs issue in order 0,1,2,3 on consecutive cycles; a second burst then starts at port 0.
- Backpressure: eng_ready=0 with port 0 streaming cmd=1 every cycle -> one request sits in the slot, FIFO fills after 4 more, req_accept[0]=0, the next push sets drop_err[0]=1, and eng fields stay stable; on releasing eng_ready, exactly 5 requests drain in order.
- Response routing: eng_resp=2'b01, eng_resp_tag=4'b11_10, eng_resp_data=32'hDEAD_BEEF -> next cycle port 3 shows out_resp=01, out_tag=2, out_data=DEADBEEF; ports 0-2 show out_resp=0.
- Simultaneous push/pop at full: port 1 full, eng_ready=1 with a new push the same cycle -> push accepted, count stays 4, no drop_err.

Source files
------------

// File: rtl/calc_mux_pkg.sv
// Shared types and constants for the calculator request multiplexer.
package calc_mux_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned TAG_W  = 2;

  localparam logic [1:0]       RESP_NONE = 2'b00;
  localparam logic [1:0]       RESP_OK   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_NOP   = '0;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  d1;
    logic [REG_W-1:0]  d2;
    logic [REG_W-1:0]  r1;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/calc_req_fifo.sv
// Per-port request FIFO; head is visible combinationally (first-word fall-through).
module calc_req_fifo
  import calc_mux_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = req_t
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  T                     i_data,
  output T                     o_head_c,
  output logic                 o_full_c,
  output logic                 o_empty_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];

  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/calc_req_mux.sv
// Multi-port front-end: per-port FIFOs, round-robin arbitration onto one
// engine channel, and tag-based routing of engine responses back to ports.
module calc_req_mux #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned PID_W      = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*REG_W-1:0]  req_d1,
  input  logic [NUM_PORTS*REG_W-1:0]  req_d2,
  input  logic [NUM_PORTS*REG_W-1:0]  req_r1,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS-1:0]        req_accept,
  output logic [NUM_PORTS-1:0]        drop_err,
  output logic                        eng_valid,
  input  logic                        eng_ready,
  output logic [CMD_W-1:0]            eng_cmd,
  output logic [DATA_W-1:0]           eng_data,
  output logic [REG_W-1:0]            eng_d1,
  output logic [REG_W-1:0]            eng_d2,
  output logic [REG_W-1:0]            eng_r1,
  output logic [PID_W+TAG_W-1:0]      eng_tag,
  input  logic [1:0]                  eng_resp,
  input  logic [DATA_W-1:0]           eng_resp_data,
  input  logic [PID_W+TAG_W-1:0]      eng_resp_tag,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);

  import calc_mux_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  d1;
    logic [REG_W-1:0]  d2;
    logic [REG_W-1:0]  r1;
    logic [TAG_W-1:0]  tag;
  } port_req_t;

  port_req_t            w_push_req [NUM_PORTS];
  port_req_t            w_head     [NUM_PORTS];
  logic [CNT_W-1:0]     w_count    [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req_vld;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_drop;

  logic                 w_slot_free;
  logic                 w_grant_vld;
  logic [PID_W-1:0]     w_grant_id;
  logic [PID_W-1:0]     w_idx;

  logic                 r_eng_valid;
  port_req_t            r_eng_req;
  logic [PID_W-1:0]     r_eng_pid;
  logic [PID_W-1:0]     r_rr_ptr;
  logic [NUM_PORTS-1:0] r_drop_err;

  logic [PID_W-1:0]     w_resp_pid;
  logic [TAG_W-1:0]     w_resp_tag;
  logic [1:0]           r_out_resp [NUM_PORTS];
  logic [DATA_W-1:0]    r_out_data [NUM_PORTS];
  logic [TAG_W-1:0]     r_out_tag  [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_push_req[p] = '{cmd:  req_cmd_in [p*CMD_W  +: CMD_W],
                             data: req_data_in[p*DATA_W +: DATA_W],
                             d1:   req_d1     [p*REG_W  +: REG_W],
                             d2:   req_d2     [p*REG_W  +: REG_W],
                             r1:   req_r1     [p*REG_W  +: REG_W],
                             tag:  req_tag_in [p*TAG_W  +: TAG_W]};
    assign w_req_vld[p] = (w_push_req[p].cmd != CMD_W'(CMD_NOP));
    assign w_pop[p]     = w_slot_free && w_grant_vld && (w_grant_id == PID_W'(p));
    assign w_drop[p]    = w_req_vld[p] && w_full[p] && !w_pop[p];
    assign req_accept[p] = (w_count[p] != CNT_W'(FIFO_DEPTH));

    calc_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (port_req_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_req_vld[p]),
      .i_pop     (w_pop[p]),
      .i_data    (w_push_req[p]),
      .o_head_c  (w_head[p]),
      .o_full_c  (w_full[p]),
      .o_empty_c (w_empty[p]),
      .o_count   (w_count[p])
    );

    assign out_resp[p*2     +: 2]      = r_out_resp[p];
    assign out_data[p*DATA_W +: DATA_W] = r_out_data[p];
    assign out_tag [p*TAG_W  +: TAG_W]  = r_out_tag[p];
  end

  assign w_slot_free = !r_eng_valid || eng_ready;

  // Round-robin: first non-empty port at or after the pointer, wrapping.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_idx = PID_W'((32'(r_rr_ptr) + i) % NUM_PORTS);
      if (!w_grant_vld && !w_empty[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eng_valid <= 1'b0;
      r_eng_req   <= '0;
      r_eng_pid   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_slot_free) begin
      if (w_grant_vld) begin
        r_eng_valid <= 1'b1;
        r_eng_req   <= w_head[w_grant_id];
        r_eng_pid   <= w_grant_id;
        r_rr_ptr    <= PID_W'((32'(w_grant_id) + 32'd1) % NUM_PORTS);
      end else begin
        r_eng_valid <= 1'b0;
      end
    end
  end

  assign eng_valid = r_eng_valid;
  assign eng_cmd   = r_eng_req.cmd;
  assign eng_data  = r_eng_req.data;
  assign eng_d1    = r_eng_req.d1;
  assign eng_d2    = r_eng_req.d2;
  assign eng_r1    = r_eng_req.r1;
  assign eng_tag   = {r_eng_pid, r_eng_req.tag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop_err <= '0;
    else     r_drop_err <= r_drop_err | w_drop;
  end

  assign drop_err = r_drop_err;

  // Response demux; a port ID with no matching port simply selects nobody.
  assign w_resp_pid = eng_resp_tag[PID_W+TAG_W-1 -: PID_W];
  assign w_resp_tag = eng_resp_tag[TAG_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_out_resp[p] <= RESP_NONE;
        r_out_data[p] <= '0;
        r_out_tag[p]  <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if ((eng_resp != RESP_NONE) && (w_resp_pid == PID_W'(p))) begin
          r_out_resp[p] <= eng_resp;
          r_out_data[p] <= eng_resp_data;
          r_out_tag[p]  <= w_resp_tag;
        end else begin
          r_out_resp[p] <= RESP_NONE;
        end
      end
    end
  end

endmodule
